nx_xrfb_fifo_ctrl: RTL and testbench
====================================

Name: nx_xrfb_fifo_ctrl

Overview:
Synchronous FIFO controller that drives one NX_XRFB_64x18 register-file primitive as its storage array. It sits directly upstream of the XRFB. It generates the write address, write enables and read address, and forwards write data. It also registers the XRFB's asynchronous read port into a clean, valid-qualified output. It gives mapped designs a 64-entry, 18-bit FIFO with occupancy and error flags, using only fabric flops for control.

Parameters:
AFULL_LVL, 56, AFULL asserted when COUNT >= AFULL_LVL (legal 1..64)
AEMPTY_LVL, 8, AEMPTY asserted when COUNT <= AEMPTY_LVL (legal 0..63)

Ports:
CK  input  1  single clock; also drives XRFB WCK externally with wck_edge=0
R  input  1  reset: asynchronous, active-low
CLR  input  1  synchronous flush, active-high
PUSH  input  1  write request
DI  input  18  write data
POP  input  1  read request
DO  output  18  registered read data
DO_VLD  output  1  DO holds newly popped word (one-cycle pulse)
FULL  output  1  COUNT == 64
EMPTY  output  1  COUNT == 0
AFULL  output  1  almost full
AEMPTY  output  1  almost empty
COUNT  output  7  occupancy 0..64
OVF  output  1  sticky: push attempted while full
UDF  output  1  sticky: pop attempted while empty
XI  output  18  to XRFB I (equals DI, combinational)
XWA  output  6  to XRFB WA (write pointer)
XWE  output  1  to XRFB WE
XWEA  output  1  to XRFB WEA (tied 1)
XRA  output  6  to XRFB RA (read pointer)
XO  input  18  from XRFB O (asynchronous read of XRA)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (R=0), immediate:
  - wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, AEMPTY=1, AFULL=0.
  - DO=0, DO_VLD=0, OVF=0, UDF=0.
  - XWE=0 combinationally while R=0.
  - XRFB contents are not cleared.
- Acceptance:
  - push_ok = PUSH & !FULL & !CLR.
  - pop_ok = POP & !EMPTY & !CLR.
  - Both evaluated on pre-edge state.
  - A push while FULL is rejected even with a simultaneous pop; no write-through.
- Write path:
  - XWE = push_ok, XWA = wptr, XI = DI.
  - The XRFB captures the word at the rising CK edge.
  - wptr increments modulo 64 (6-bit natural wrap 63->0).
- Read path:
  - XRA = rptr continuously.
  - On pop_ok, DO <= XO at the edge and rptr increments modulo 64.
  - DO_VLD <= pop_ok, so read latency is 1 cycle from pop acceptance.
  - DO holds its value when no pop occurs.
- Count update:
  - +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
  - Flags are registered and derived from the next COUNT, so they are valid in the same cycle as COUNT.
- No read/write address hazard:
  - pop_ok requires COUNT>=1, so the rptr entry was written at least one edge earlier.
  - When COUNT==64, pushes are blocked, so wptr==rptr never coincides with a write to a readable entry.
- Simultaneous push and pop:
  - At COUNT=0: push only.
  - At COUNT=64: pop only.
- CLR has priority over PUSH/POP:
  - Sets wptr=rptr=0, COUNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, DO_VLD=0.
  - DO, OVF and UDF are held; XWE=0 that cycle.
- OVF sets on PUSH & FULL & !CLR; UDF sets on POP & EMPTY & !CLR.
  - Both are cleared only by R.
- Reset mid-operation: returns to the reset state above. A write in flight in the same cycle as the R assertion is not guaranteed.

Test Plan:
- Reset then idle: R=0 for 3 cycles, release -> EMPTY=1, COUNT=0, DO=0, DO_VLD=0, XWE=0, XWA=XRA=0.
- Fill: push 64 words DI=0x00000+i -> XWA walks 0..63. AFULL rises when COUNT reaches 56. FULL=1 at COUNT=64. 65th push -> XWE=0, OVF=1, COUNT stays 64.
- Drain with XRFB model attached: pop 64 times -> DO_VLD pulses one cycle after each pop, DO=0x00000..0x0003F in order. AEMPTY=1 at COUNT=8, EMPTY=1 at 0. Extra pop -> UDF=1, DO_VLD=0, DO holds 0x0003F.
- Wrap and concurrent traffic: after fill/drain, push 10 then push+pop for 100 cycles -> COUNT constant 10. XWA/XRA wrap 63->0. DO sequence matches the written sequence with no loss or duplication.
- Full boundary: COUNT=64 with PUSH=POP=1 -> pop accepted, push rejected, COUNT=63, OVF=1. At COUNT=0 with both asserted -> push accepted, no DO_VLD, COUNT=1.
- CLR and mid-op reset: COUNT=20, assert CLR with PUSH=POP=1 -> next cycle COUNT=0, EMPTY=1, XWE=0, OVF/UDF unchanged. Refill 5, drop R asynchronously mid-cycle -> flags reset immediately without waiting for CK, sticky flags clear.

Source files
------------

// File: rtl/nx_xrfb_fifo_ctrl_if.sv
// Bundle of the FIFO user-side handshake, status flags and the NX_XRFB_64x18 port wiring.
// "slave" is the controller's view; "master" is the environment (user logic plus XRFB).
interface nx_xrfb_fifo_ctrl_if;
  logic        clr;
  logic        push;
  logic [17:0] di;
  logic        pop;
  logic [17:0] dout;
  logic        dout_vld;
  logic        full;
  logic        empty;
  logic        afull;
  logic        aempty;
  logic [6:0]  count;
  logic        ovf;
  logic        udf;
  logic [17:0] xi;
  logic [5:0]  xwa;
  logic        xwe;
  logic        xwea;
  logic [5:0]  xra;
  logic [17:0] xo;

  modport slave (
    input  clr, push, di, pop, xo,
    output dout, dout_vld, full, empty, afull, aempty, count, ovf, udf,
    output xi, xwa, xwe, xwea, xra
  );

  modport master (
    output clr, push, di, pop, xo,
    input  dout, dout_vld, full, empty, afull, aempty, count, ovf, udf,
    input  xi, xwa, xwe, xwea, xra
  );
endinterface

// File: rtl/nx_xrfb_fifo_ctrl.sv
// 64x18 synchronous FIFO controller driving one NX_XRFB_64x18 register file.
// Pointers, occupancy and flags live in fabric flops; the XRFB async read port is registered into dout.
module nx_xrfb_fifo_ctrl #(
  parameter int unsigned AFULL_LVL  = 56,
  parameter int unsigned AEMPTY_LVL = 8
) (
  input  logic                   i_ck,
  input  logic                   i_rst_n,
  nx_xrfb_fifo_ctrl_if.slave     io_fifo
);

  localparam logic [6:0] DEPTH = 7'd64;

  logic [5:0]  r_wptr;
  logic [5:0]  r_rptr;
  logic [6:0]  r_count;
  logic        r_full;
  logic        r_empty;
  logic        r_afull;
  logic        r_aempty;
  logic [17:0] r_do;
  logic        r_do_vld;
  logic        r_ovf;
  logic        r_udf;

  logic        w_push_ok;
  logic        w_pop_ok;
  logic [6:0]  w_count_next;

  // Acceptance uses the registered flags, so a push at FULL is refused even alongside a pop.
  always_comb begin
    w_push_ok    = io_fifo.push & ~r_full  & ~io_fifo.clr;
    w_pop_ok     = io_fifo.pop  & ~r_empty & ~io_fifo.clr;
    w_count_next = r_count;
    if (io_fifo.clr) begin
      w_count_next = 7'd0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + 7'd1;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - 7'd1;
    end
  end

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr   <= 6'd0;
      r_rptr   <= 6'd0;
      r_count  <= 7'd0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_do     <= 18'd0;
      r_do_vld <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ovf    <= r_ovf | (io_fifo.push & r_full  & ~io_fifo.clr);
      r_udf    <= r_udf | (io_fifo.pop  & r_empty & ~io_fifo.clr);
      r_count  <= w_count_next;
      r_full   <= (w_count_next == DEPTH);
      r_empty  <= (w_count_next == 7'd0);
      r_afull  <= (w_count_next >= 7'(AFULL_LVL));
      r_aempty <= (w_count_next <= 7'(AEMPTY_LVL));
      r_do_vld <= w_pop_ok;
      if (io_fifo.clr) begin
        r_wptr <= 6'd0;
        r_rptr <= 6'd0;
      end else begin
        if (w_push_ok) begin
          r_wptr <= r_wptr + 6'd1;
        end
        if (w_pop_ok) begin
          r_rptr <= r_rptr + 6'd1;
          r_do   <= io_fifo.xo;
        end
      end
    end
  end

  // Write enable is gated by reset so the XRFB never sees a stray write while held in reset.
  assign io_fifo.xwe      = w_push_ok & i_rst_n;
  assign io_fifo.xwa      = r_wptr;
  assign io_fifo.xi       = io_fifo.di;
  assign io_fifo.xwea     = 1'b1;
  assign io_fifo.xra      = r_rptr;

  assign io_fifo.dout     = r_do;
  assign io_fifo.dout_vld = r_do_vld;
  assign io_fifo.full     = r_full;
  assign io_fifo.empty    = r_empty;
  assign io_fifo.afull    = r_afull;
  assign io_fifo.aempty   = r_aempty;
  assign io_fifo.count    = r_count;
  assign io_fifo.ovf      = r_ovf;
  assign io_fifo.udf      = r_udf;

endmodule

// File: tb/tb_nx_xrfb_fifo_ctrl.sv
// Self-checking bench for nx_xrfb_fifo_ctrl with an attached XRFB storage model.
// A queue-based FIFO model predicts occupancy, flags, read data and sticky errors.
module tb_nx_xrfb_fifo_ctrl;
  localparam int AFL = 56;
  localparam int AEL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nx_xrfb_fifo_ctrl_if bus ();

  nx_xrfb_fifo_ctrl #(
    .AFULL_LVL  (AFL),
    .AEMPTY_LVL (AEL)
  ) dut (
    .i_ck    (clk),
    .i_rst_n (rst_n),
    .io_fifo (bus)
  );

  // XRFB primitive: synchronous write, asynchronous read.
  logic [17:0] xrfb_mem [64];
  always @(posedge clk) if (bus.xwe) xrfb_mem[bus.xwa] <= bus.xi;
  assign bus.xo = xrfb_mem[bus.xra];

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] m_q [$];
  logic        m_ovf, m_udf, m_vld;
  logic [17:0] m_do;
  int          m_wa, m_ra;

  logic        exp_xwe;
  logic [5:0]  exp_wa, exp_ra;
  logic        obs_xwe;
  logic [5:0]  obs_xwa, obs_xra;
  logic [17:0] obs_xi;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_do = 18'd0;
    m_wa = 0; m_ra = 0;
  endtask

  // Drive one cycle, capture pre-edge XRFB-side outputs, advance the model, settle after the edge.
  task automatic cyc(input logic p, input logic q, input logic c, input logic [17:0] d);
    int sz;
    bus.push = p; bus.pop = q; bus.clr = c; bus.di = d;
    #1;
    obs_xwe = bus.xwe; obs_xwa = bus.xwa; obs_xra = bus.xra; obs_xi = bus.xi;
    sz      = m_q.size();
    exp_wa  = 6'(m_wa);
    exp_ra  = 6'(m_ra);
    exp_xwe = p && !c && (sz < 64);
    if (c) begin
      m_q.delete(); m_wa = 0; m_ra = 0; m_vld = 1'b0;
    end else begin
      if (p && sz == 64) m_ovf = 1'b1;
      if (q && sz == 0)  m_udf = 1'b1;
      m_vld = q && (sz > 0);
      if (m_vld) begin m_do = m_q.pop_front(); m_ra = (m_ra + 1) % 64; end
      if (exp_xwe) begin m_q.push_back(d); m_wa = (m_wa + 1) % 64; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.di = 18'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.push = 1'b1; bus.pop = 1'b0; bus.clr = 1'b0; bus.di = 18'h155;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.xwe !== 1'b0) begin n_fail++; $display("FAIL reset_xwe_gated: got %b exp 0", bus.xwe); end
    bus.push = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_checks++; if ({bus.empty, bus.full, bus.aempty, bus.afull} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got e%b f%b ae%b af%b exp 1010", bus.empty, bus.full, bus.aempty, bus.afull); end
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    n_checks++; if ({bus.dout, bus.dout_vld, bus.ovf, bus.udf} !== 21'd0) begin n_fail++; $display("FAIL reset_out: got do=%h vld=%b ovf=%b udf=%b exp 0", bus.dout, bus.dout_vld, bus.ovf, bus.udf); end
    n_checks++; if ({bus.xwe, bus.xwa, bus.xra, bus.xwea} !== 14'd1) begin n_fail++; $display("FAIL reset_xrfb: got xwe=%b xwa=%0d xra=%0d xwea=%b exp 0/0/0/1", bus.xwe, bus.xwa, bus.xra, bus.xwea); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 18'(i));
      n_checks++; if (obs_xwa !== 6'(i) || obs_xwe !== 1'b1 || obs_xi !== 18'(i)) begin n_fail++; $display("FAIL fill_write[%0d]: got xwa=%0d xwe=%b xi=%h exp %0d/1/%h", i, obs_xwa, obs_xwe, obs_xi, i, i); end
      n_checks++; if (bus.count !== 7'(i + 1) || bus.afull !== (i + 1 >= AFL) || bus.full !== (i == 63)) begin n_fail++; $display("FAIL fill_status[%0d]: got cnt=%0d af=%b f=%b", i, bus.count, bus.afull, bus.full); end
    end
    cyc(1'b1, 1'b0, 1'b0, 18'h3ffff);
    n_checks++; if (obs_xwe !== 1'b0 || bus.ovf !== 1'b1 || bus.count !== 7'd64) begin n_fail++; $display("FAIL fill_overflow: got xwe=%b ovf=%b cnt=%0d exp 0/1/64", obs_xwe, bus.ovf, bus.count); end
  endtask

  task automatic test_drain();
    logic [17:0] held;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 18'd0);
      n_checks++; if (bus.dout_vld !== 1'b1 || bus.dout !== 18'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got vld=%b do=%h exp 1/%h", i, bus.dout_vld, bus.dout, i); end
      n_checks++; if (bus.count !== 7'(63 - i) || bus.aempty !== (63 - i <= AEL) || bus.empty !== (i == 63)) begin n_fail++; $display("FAIL drain_status[%0d]: got cnt=%0d ae=%b e=%b", i, bus.count, bus.aempty, bus.empty); end
      if (i % 8 == 3) begin
        held = bus.dout;
        cyc(1'b0, 1'b0, 1'b0, 18'd0);
        n_checks++; if (bus.dout_vld !== 1'b0 || bus.dout !== 18'(i)) begin n_fail++; $display("FAIL drain_hold[%0d]: got vld=%b do=%h exp 0/%h", i, bus.dout_vld, bus.dout, held); end
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 18'd0);
    n_checks++; if (bus.udf !== 1'b1 || bus.dout_vld !== 1'b0 || bus.dout !== 18'h0003f) begin n_fail++; $display("FAIL drain_underflow: got udf=%b vld=%b do=%h exp 1/0/0003f", bus.udf, bus.dout_vld, bus.dout); end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 18'($urandom));
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 18'($urandom));
      if (exp_wa == 6'd63) wraps++;
      n_checks++; if (bus.count !== 7'd10 || bus.dout_vld !== 1'b1 || bus.dout !== m_do) begin n_fail++; $display("FAIL wrap[%0d]: got cnt=%0d vld=%b do=%h exp 10/1/%h", i, bus.count, bus.dout_vld, bus.dout, m_do); end
      n_checks++; if (obs_xwa !== exp_wa || obs_xra !== exp_ra) begin n_fail++; $display("FAIL wrap_ptr[%0d]: got xwa=%0d xra=%0d exp %0d/%0d", i, obs_xwa, obs_xra, exp_wa, exp_ra); end
    end
    n_checks++; if (wraps < 1 || bus.xwa !== 6'(m_wa) || bus.xra !== 6'(m_ra)) begin n_fail++; $display("FAIL wrap_seen: got xwa=%0d xra=%0d wraps=%0d exp %0d/%0d", bus.xwa, bus.xra, wraps, m_wa, m_ra); end
  endtask

  task automatic test_full_boundary();
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, 18'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 18'h2aaaa);
    n_checks++; if (obs_xwe !== 1'b0 || bus.count !== 7'd63 || bus.ovf !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_both: got xwe=%b cnt=%0d ovf=%b f=%b exp 0/63/1/0", obs_xwe, bus.count, bus.ovf, bus.full); end
    n_checks++; if (bus.dout_vld !== 1'b1 || bus.dout !== m_do) begin n_fail++; $display("FAIL full_both_data: got vld=%b do=%h exp 1/%h", bus.dout_vld, bus.dout, m_do); end
    for (int i = 0; i < 63; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 18'd0);
      n_checks++; if (bus.dout !== m_do || bus.count !== 7'(m_q.size())) begin n_fail++; $display("FAIL full_drain[%0d]: got do=%h cnt=%0d exp %h/%0d", i, bus.dout, bus.count, m_do, m_q.size()); end
    end
    cyc(1'b1, 1'b1, 1'b0, 18'h15555);
    n_checks++; if (obs_xwe !== 1'b1 || bus.count !== 7'd1 || bus.dout_vld !== 1'b0 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL empty_both: got xwe=%b cnt=%0d vld=%b e=%b exp 1/1/0/0", obs_xwe, bus.count, bus.dout_vld, bus.empty); end
  endtask

  task automatic test_clr_reset();
    logic [17:0] held;
    cyc(1'b0, 1'b1, 1'b0, 18'd0);
    cyc(1'b0, 1'b1, 1'b0, 18'd0);
    n_checks++; if (bus.udf !== 1'b1 || bus.dout !== 18'h15555) begin n_fail++; $display("FAIL clr_prep: got udf=%b do=%h exp 1/15555", bus.udf, bus.dout); end
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 18'($urandom));
    held = bus.dout;
    cyc(1'b1, 1'b1, 1'b1, 18'h00abc);
    n_checks++; if (obs_xwe !== 1'b0 || bus.count !== 7'd0 || {bus.empty, bus.aempty, bus.full, bus.afull, bus.dout_vld} !== 5'b11000) begin n_fail++; $display("FAIL clr_state: got xwe=%b cnt=%0d e=%b ae=%b f=%b af=%b vld=%b", obs_xwe, bus.count, bus.empty, bus.aempty, bus.full, bus.afull, bus.dout_vld); end
    n_checks++; if (bus.ovf !== m_ovf || bus.udf !== m_udf || bus.dout !== held || bus.xwa !== 6'd0 || bus.xra !== 6'd0) begin n_fail++; $display("FAIL clr_held: got ovf=%b udf=%b do=%h xwa=%0d xra=%0d exp %b/%b/%h/0/0", bus.ovf, bus.udf, bus.dout, bus.xwa, bus.xra, m_ovf, m_udf, held); end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 18'($urandom));
    n_checks++; if (bus.count !== 7'd5) begin n_fail++; $display("FAIL refill_count: got %0d exp 5", bus.count); end
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.count !== 7'd0 || {bus.empty, bus.aempty, bus.ovf, bus.udf, bus.dout_vld} !== 5'b11000 || bus.dout !== 18'd0) begin n_fail++; $display("FAIL async_reset: got cnt=%0d e=%b ae=%b ovf=%b udf=%b vld=%b do=%h", bus.count, bus.empty, bus.aempty, bus.ovf, bus.udf, bus.dout_vld, bus.dout); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [14:0] exp_st, obs_st;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 100) < 60, ($urandom % 100) < ((i / 150) % 2 ? 70 : 40), ($urandom % 100) < 2, 18'($urandom));
      exp_st = {7'(m_q.size()), m_q.size() == 64, m_q.size() == 0, m_q.size() >= AFL, m_q.size() <= AEL, m_vld, m_ovf, m_udf};
      obs_st = {bus.count, bus.full, bus.empty, bus.afull, bus.aempty, bus.dout_vld, bus.ovf, bus.udf};
      n_checks++; if (obs_st !== exp_st || bus.dout !== m_do) begin n_fail++; $display("FAIL random_status[%0d]: got %h do=%h exp %h do=%h", i, obs_st, bus.dout, exp_st, m_do); end
      n_checks++; if (obs_xwe !== exp_xwe || obs_xwa !== exp_wa || obs_xra !== exp_ra) begin n_fail++; $display("FAIL random_xrfb[%0d]: got xwe=%b xwa=%0d xra=%0d exp %b/%0d/%0d", i, obs_xwe, obs_xwa, obs_xra, exp_xwe, exp_wa, exp_ra); end
    end
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.di = 18'd0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_boundary();
    test_clr_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
